// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: fetch-stage bus bundling ROM port, decode handshake, redirect and halt status
interface instruction_fetch_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 16
);
  logic                  enable;
  logic [ADDR_WIDTH-1:0] pm_addr;
  logic [DATA_WIDTH-1:0] pm_data;
  logic                  inst_valid;
  logic                  inst_ready;
  logic [DATA_WIDTH-1:0] inst_data;
  logic [ADDR_WIDTH-1:0] inst_pc;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_addr;
  logic                  halted;
  modport master (
    input  enable, pm_data, inst_ready, redirect_valid, redirect_addr,
    output pm_addr, inst_valid, inst_data, inst_pc, halted
  );
  modport slave (
    output enable, pm_data, inst_ready, redirect_valid, redirect_addr,
    input  pm_addr, inst_valid, inst_data, inst_pc, halted
  );
endinterface

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC/ROM issue with credit-limited token pipe and FWFT instruction FIFO
module instruction_fetch #(
  parameter int          ADDR_WIDTH   = 11,
  parameter int          DATA_WIDTH   = 16,
  parameter int          READ_LATENCY = 2,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [4:0]  HLT_OPCODE   = 5'b00000
) (
  input  logic clka,
  input  logic rsta_n,
  instruction_fetch_if.master bus
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic                    halted_q, halted_d;
  logic [READ_LATENCY-1:0] tv_q, tv_d;
  logic [ADDR_WIDTH-1:0]   tpc_q [READ_LATENCY];
  logic [ADDR_WIDTH-1:0]   tpc_d [READ_LATENCY];
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [PW-1:0]           rd_q, rd_d, wr_q, wr_d;
  logic [DATA_WIDTH-1:0]   mem_data [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]   mem_pc [FIFO_DEPTH];
  logic [CW:0]             infl;
  logic                    empty, pop, hlt, redir, flush, issue, wr;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(FIFO_DEPTH - 1) ? '0 : p + PW'(1);
  endfunction
  always_comb begin
    infl = '0;
    for (int i = 0; i < READ_LATENCY; i++) infl = infl + {{CW{1'b0}}, tv_q[i]};
    empty = cnt_q == '0;
    pop = !empty && bus.inst_ready;
    hlt = pop && mem_data[rd_q][DATA_WIDTH-1 -: 5] == HLT_OPCODE;
    redir = bus.redirect_valid && !halted_q && !hlt;
    flush = redir || hlt;
    // credit: buffered plus in-flight reads never exceed the FIFO capacity
    issue = bus.enable && !halted_q && !bus.redirect_valid && !hlt &&
            ({1'b0, cnt_q} + infl < (CW+1)'(FIFO_DEPTH));
    wr = tv_q[READ_LATENCY-1] && !flush;
    pc_d = redir ? bus.redirect_addr : issue ? pc_q + ADDR_WIDTH'(1) : pc_q;
    halted_d = halted_q || hlt;
    tv_d = flush ? '0 : READ_LATENCY'({tv_q, issue});
    tpc_d[0] = pc_q;
    for (int i = 1; i < READ_LATENCY; i++) tpc_d[i] = tpc_q[i-1];
    cnt_d = flush ? '0 : cnt_q + CW'(wr) - CW'(pop);
    rd_d = flush ? '0 : pop ? nxt(rd_q) : rd_q;
    wr_d = flush ? '0 : wr ? nxt(wr_q) : wr_q;
  end
  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      pc_q     <= '0;
      halted_q <= 1'b0;
      tv_q     <= '0;
      cnt_q    <= '0;
      rd_q     <= '0;
      wr_q     <= '0;
    end else begin
      pc_q     <= pc_d;
      halted_q <= halted_d;
      tv_q     <= tv_d;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
    end
  end
  // storage needs no reset: tv_q and cnt_q gate every use of it
  always_ff @(posedge clka) begin
    if (wr) begin
      mem_data[wr_q] <= bus.pm_data;
      mem_pc[wr_q]   <= tpc_q[READ_LATENCY-1];
    end
    tpc_q <= tpc_d;
  end
  a_no_overflow: assert property (@(posedge clka) disable iff (!rsta_n)
    !(wr && !pop && cnt_q == CW'(FIFO_DEPTH)));
  assign bus.pm_addr    = pc_q;
  assign bus.inst_valid = !empty;
  assign bus.inst_data  = empty ? '0 : mem_data[rd_q];
  assign bus.inst_pc    = empty ? '0 : mem_pc[rd_q];
  assign bus.halted     = halted_q;
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed plus random stimulus against an in-order fetch-stream model
module tb_instruction_fetch;
  localparam int AW = 11;
  localparam int DW = 16;
  logic clka = 1'b0;
  logic rsta_n = 1'b0;
  always #5 clka = ~clka;
  instruction_fetch_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();
  instruction_fetch #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(2), .FIFO_DEPTH(4), .HLT_OPCODE(5'b00000)
  ) dut (
    .clka(clka), .rsta_n(rsta_n), .bus(bus)
  );
  logic [DW-1:0] rom [2**AW];
  logic [AW-1:0] ra;
  always @(posedge clka) begin
    ra <= bus.pm_addr;
    bus.pm_data <= rom[ra];
  end
  int vectors = 0;
  int miscompares = 0;
  int hs_cnt = 0;
  logic [AW-1:0] exp_pc, a;
  bit m_halt, p_stall, p_flush;
  logic [DW-1:0] p_data;
  logic [AW-1:0] p_pc;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    exp_pc = '0;
    m_halt = 0;
    p_stall = 0;
    p_flush = 0;
  endtask
  task automatic cyc();
    logic hs;
    @(negedge clka);
    if (m_halt) begin
      chk("halt_flag", bus.halted, 1);
      chk("halt_novalid", bus.inst_valid, 0);
    end
    if (p_stall && !p_flush) begin
      chk("hold_valid", bus.inst_valid, 1);
      chk("hold_data", bus.inst_data, p_data);
      chk("hold_pc", bus.inst_pc, p_pc);
    end
    hs = bus.inst_valid && bus.inst_ready;
    if (hs) begin
      hs_cnt++;
      chk("data", bus.inst_data, rom[exp_pc]);
      chk("pc", bus.inst_pc, exp_pc);
      if (rom[exp_pc][15:11] == 5'b00000) m_halt = 1;
      else exp_pc = exp_pc + 1'b1;
    end
    p_flush = bus.redirect_valid && !m_halt;
    if (p_flush) exp_pc = bus.redirect_addr;
    p_stall = bus.inst_valid && !bus.inst_ready;
    p_data = bus.inst_data;
    p_pc = bus.inst_pc;
    @(posedge clka);
    #1;
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, bus.inst_valid, 0);
    chk({tag, "_data"}, bus.inst_data, 0);
    chk({tag, "_pc"}, bus.inst_pc, 0);
    chk({tag, "_addr"}, bus.pm_addr, 0);
    chk({tag, "_halted"}, bus.halted, 0);
  endtask
  task automatic rst_pulse();
    rsta_n = 1'b0;
    model_reset();
    @(posedge clka);
    #1;
    rsta_n = 1'b1;
  endtask
  task automatic redirect_to(input logic [AW-1:0] t);
    bus.redirect_valid = 1'b1;
    bus.redirect_addr = t;
    cyc();
    bus.redirect_valid = 1'b0;
  endtask
  initial begin
    for (int i = 0; i < 2**AW; i++) rom[i] = DW'(16'h0800 + i);
    bus.enable = 1'b1;
    bus.inst_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_addr = '0;
    model_reset();
    repeat (2) @(posedge clka);
    #1;
    chk_reset_vals("rst");
    rsta_n = 1'b1;
    cyc(); chk("lat1", bus.inst_valid, 0);
    cyc(); chk("lat2", bus.inst_valid, 0);
    cyc(); chk("lat3", bus.inst_valid, 1);
    chk("first_pc", bus.inst_pc, 0);
    chk("first_data", bus.inst_data, 16'h0800);
    hs_cnt = 0;
    repeat (20) cyc();
    chk("no_bubble", hs_cnt, 20);
    bus.inst_ready = 1'b0;
    repeat (10) cyc();
    chk("full_addr", bus.pm_addr, AW'(bus.inst_pc + 4));
    a = bus.pm_addr;
    cyc();
    chk("full_stop", bus.pm_addr, a);
    bus.inst_ready = 1'b1;
    repeat (5) cyc();
    bus.inst_ready = 1'b0;
    repeat (2) cyc();
    bus.inst_ready = 1'b1;
    redirect_to(AW'(12'h100));
    chk("rd_flush", bus.inst_valid, 0);
    cyc(); chk("rd_lat1", bus.inst_valid, 0);
    cyc(); chk("rd_lat2", bus.inst_valid, 0);
    cyc(); chk("rd_lat3", bus.inst_valid, 1);
    chk("rd_pc", bus.inst_pc, 12'h100);
    repeat (5) cyc();
    redirect_to(AW'(2046));
    repeat (3) cyc();
    chk("wrap0", bus.inst_pc, 2046);
    cyc(); chk("wrap1", bus.inst_pc, 2047);
    cyc(); chk("wrap2", bus.inst_pc, 0);
    cyc(); chk("wrap3", bus.inst_pc, 1);
    repeat (600) begin
      bus.inst_ready = $urandom_range(0, 3) != 0;
      bus.enable = $urandom_range(0, 7) != 0;
      bus.redirect_valid = $urandom_range(0, 24) == 0;
      bus.redirect_addr = AW'($urandom);
      cyc();
    end
    bus.redirect_valid = 1'b0;
    bus.enable = 1'b1;
    bus.inst_ready = 1'b1;
    repeat (10) cyc();
    chk("rand_stream", bus.inst_valid, 1);
    bus.inst_ready = 1'b0;
    repeat (8) cyc();
    chk("pre_async", bus.inst_valid, 1);
    #2;
    rsta_n = 1'b0;
    #1;
    chk_reset_vals("async");
    model_reset();
    @(posedge clka);
    #1;
    rsta_n = 1'b1;
    bus.inst_ready = 1'b1;
    repeat (10) cyc();
    rom[5] = 16'h0000;
    rst_pulse();
    repeat (12) cyc();
    chk("hlt_model", m_halt, 1);
    a = bus.pm_addr;
    redirect_to(AW'(12'h300));
    repeat (5) cyc();
    chk("hlt_pc_frozen", bus.pm_addr, a);
    chk("hlt_sticky", bus.halted, 1);
    rst_pulse();
    chk("hlt_cleared", bus.halted, 0);
    repeat (4) cyc();
    chk("restart_pc", bus.inst_pc, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
